alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
// Command initiator for the 8-bit ALU. Holds a small program of {opcode, operand}
// steps and issues them one at a time on the ALU's selector/data_in/enable interface.
// After each result-producing step it waits a fixed latency and captures the ALU's Y.
// Software or the board top loads the program, pulses start, and reads results/done.
// PARAMETERS
// DEPTH    8  program entries (power of two, 2..16)
// AW       3  program address width, log2(DEPTH)
// ALU_LAT  1  cycles from enable-high edge until Y is valid (1..4)
// PORTS
// clock        in   1   single clock, all state on rising edge
// reset        in   1   asynchronous, active-low; clears all state
// prog_we      in   1   program write strobe (honoured only when !busy)
// prog_addr    in   AW  program write address
// prog_data    in   12  {opcode[11:8], operand[7:0]}
// length       in   AW+1 steps to run (1..DEPTH), sampled on start
// start        in   1   1-cycle pulse begins a run at address 0
// abort        in   1   terminates an active run
// sel_out      out  4   drives ALU selector
// data_out     out  8   drives ALU data_in
// alu_enable   out  1   drives ALU enable; high exactly 1 cycle per step
// alu_y        in   8   ALU result Y
// result       out  8   last captured Y
// result_valid out  1   1-cycle pulse when result updates
// step         out  AW  index of step currently/last issued
// busy         out  1   high from start accepted to DONE exit
// done         out  1   1-cycle pulse at end of a complete run
// prog_err     out  1   sticky: prog_we/start seen while busy, or bad length; cleared by start while idle
// BEHAVIOUR
// - Reset (reset=0, async): FSM=IDLE; sel_out, data_out, result, step = 0; all 1-bit outputs 0.
//   Program memory contents undefined after reset; not cleared.
// - FSM: IDLE -> ISSUE -> WAIT -> (CAPTURE) -> ISSUE | DONE -> IDLE.
// - IDLE: start with 1<=length<=DEPTH -> busy=1, step=0, ISSUE next cycle. length=0 or
//   >DEPTH -> no run, prog_err=1. start and prog_we same cycle: write done, then run starts.
// - ISSUE (1 cycle): sel_out/data_out = program[step], alu_enable=1.
//   sel_out/data_out hold that value until next ISSUE.
// - WAIT: ALU_LAT cycles, alu_enable=0.
// - CAPTURE: opcode 0000..1100 -> result<=alu_y, result_valid=1. Opcodes 1101 store,
//   1110 swap, 1111 load: no capture, CAPTURE skipped.
// - After step: if step==length-1 -> DONE (done=1 for 1 cycle, busy=0) -> IDLE;
//   else step+1 -> ISSUE. Issue-to-issue spacing: ALU_LAT+2 cycles (capturing),
//   ALU_LAT+1 (non-capturing).
// - abort: any non-IDLE state -> IDLE next cycle, busy=0, done NOT pulsed, result retained;
//   an enable already issued is not retracted. abort in IDLE ignored; abort beats start.
// - start while busy: ignored, prog_err=1. prog_we while busy: ignored, prog_err=1.
// - Mid-run async reset: outputs to reset values at once; no done.
// - step never wraps; length==DEPTH runs entries 0..DEPTH-1 exactly once.
// STRUCTURE
// - alu_pkg: opcode localparams (OP_ADD=4'h0 .. OP_NOT=4'hB, OP_NEG=4'hC, OP_STORE=4'hD,
//   OP_SWAP=4'hE, OP_LOAD=4'hF), function op_has_result(op), FSM state enum.
//   alu_pkg is shared with the ALU.
// - One sub-module seq_prog_mem: DEPTH x 12 regfile, sync write, async read.
// - FSM + WAIT counter + step counter stay in this module.
// TESTING (bench pairs block with the ALU or a cycle-accurate model; B=0 after reset)
// - Program {LOAD 0x05, ADD, SHL, NOT}, length=4, start -> result_valid x3,
//   results 0x05, 0x0A, 0xF5; done once; busy low after.
// - Same program, check enable spacing -> LOAD to ADD 2 cycles, ADD to SHL 3 cycles
//   (ALU_LAT=1); alu_enable never high 2 cycles running.
// - abort during WAIT of step 2 -> busy=0 next cycle, no done, result still 0x05.
// - start while busy and prog_we while busy -> prog_err=1, program unchanged, run unaffected.
// - length=0 start -> no enable, prog_err=1; length=DEPTH -> exactly DEPTH enables, step ends DEPTH-1.
// - reset asserted mid-WAIT asynchronously -> all outputs 0 before next clock edge; fresh start works.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the 8-bit ALU and its command sequencer:
//   - 4-bit opcode encodings (OP_ADD .. OP_LOAD)
//   - op_has_result(): 1 when an opcode updates the ALU result Y
//   - seq_state_t: state encoding of the alu_op_sequencer FSM
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_SHL   = 4'h5;
  localparam logic [3:0] OP_SHR   = 4'h6;
  localparam logic [3:0] OP_ROL   = 4'h7;
  localparam logic [3:0] OP_ROR   = 4'h8;
  localparam logic [3:0] OP_INC   = 4'h9;
  localparam logic [3:0] OP_DEC   = 4'hA;
  localparam logic [3:0] OP_NOT   = 4'hB;
  localparam logic [3:0] OP_NEG   = 4'hC;
  localparam logic [3:0] OP_STORE = 4'hD;
  localparam logic [3:0] OP_SWAP  = 4'hE;
  localparam logic [3:0] OP_LOAD  = 4'hF;

  // Width of one program word: {opcode[11:8], operand[7:0]}
  localparam int PROG_W = 12;

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_ISSUE   = 3'd1,
    SEQ_WAIT    = 3'd2,
    SEQ_CAPTURE = 3'd3,
    SEQ_DONE    = 3'd4
  } seq_state_t;

  // Register-move opcodes (STORE/SWAP/LOAD) sit at the top of the map and
  // leave nothing worth capturing; everything up to NEG produces a Y.
  function automatic logic op_has_result(input logic [3:0] op);
    return (op <= OP_NEG);
  endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// ---------------------------------------------------------------------------
// seq_prog_mem
// DEPTH x DW program register file: synchronous write, asynchronous read.
// Contents are deliberately not reset.
// Ports:
//   i_clk     clock (write on rising edge)
//   i_we      write enable
//   i_waddr   write address
//   i_wdata   write data
//   i_raddr   read address
//   o_rdata   read data (combinational)
// ---------------------------------------------------------------------------
module seq_prog_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 12
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Command initiator for the 8-bit ALU. Holds a program of {opcode, operand}
// steps, issues them one per ALU transaction on sel/data/enable, waits the
// ALU latency, and captures Y for result-producing opcodes.
//
// Handshake with the ALU: o_alu_enable is high for exactly one cycle per
// step, with o_sel_out/o_data_out stable during that cycle and held until
// the next issue; i_alu_y is assumed valid ALU_LAT cycles after the rising
// edge that sampled the enable, and is captured on the edge ending WAIT.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_prog_we/addr/data   program write port (ignored while busy)
//   i_length              steps to run (1..DEPTH), sampled on start
//   i_start, i_abort      run control
//   o_sel_out, o_data_out ALU selector / data_in
//   o_alu_enable          ALU enable, one cycle per step
//   i_alu_y               ALU result
//   o_result              last captured Y
//   o_result_valid        one-cycle pulse when o_result updates
//   o_step                index of the step currently / last issued
//   o_busy, o_done        run status; done pulses once per complete run
//   o_prog_err            sticky misuse flag, cleared by a valid start
//   o_state               FSM state (debug)
// ---------------------------------------------------------------------------
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int ALU_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_prog_we,
  input  logic [AW-1:0] i_prog_addr,
  input  logic [11:0]   i_prog_data,
  input  logic [AW:0]   i_length,
  input  logic          i_start,
  input  logic          i_abort,
  output logic [3:0]    o_sel_out,
  output logic [7:0]    o_data_out,
  output logic          o_alu_enable,
  input  logic [7:0]    i_alu_y,
  output logic [7:0]    o_result,
  output logic          o_result_valid,
  output logic [AW-1:0] o_step,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_prog_err,
  output logic [2:0]    o_state
);

  localparam logic [2:0]  LAT_M1  = 3'(ALU_LAT - 1);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [AW-1:0]     r_step;
  logic [AW:0]       r_len;
  logic [2:0]        r_wait_cnt;
  logic [3:0]        r_sel;
  logic [7:0]        r_data;
  logic [7:0]        r_result;
  logic              r_prog_err;

  logic              w_busy;
  logic              w_len_ok;
  logic              w_start_go;
  logic              w_mem_we;
  logic              w_last;
  logic              w_wait_end;
  logic              w_capture_op;
  logic [AW-1:0]     w_rd_addr;
  logic [PROG_W-1:0] w_mem_rdata;
  logic [PROG_W-1:0] w_fetch;

  // ---------------------------------------------------------------------
  // Program memory
  // ---------------------------------------------------------------------
  assign w_mem_we = i_prog_we && !w_busy;

  // The next word to issue: entry 0 when launching from IDLE, else step+1.
  // At step DEPTH-1 this wraps to 0, but then w_last is set and nothing is
  // issued from the wrapped address.
  assign w_rd_addr = (r_state == SEQ_IDLE) ? '0 : (r_step + 1'b1);

  seq_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (PROG_W)
  ) u_prog_mem (
    .i_clk   (i_clk),
    .i_we    (w_mem_we),
    .i_waddr (i_prog_addr),
    .i_wdata (i_prog_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_mem_rdata)
  );

  // A write landing in the same cycle as the fetch (start + prog_we to
  // entry 0) must be seen by the first issue, so forward it.
  assign w_fetch = (w_mem_we && (i_prog_addr == w_rd_addr)) ? i_prog_data
                                                           : w_mem_rdata;

  // ---------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------
  assign w_busy       = (r_state == SEQ_ISSUE) || (r_state == SEQ_WAIT) ||
                        (r_state == SEQ_CAPTURE);
  assign w_len_ok     = (i_length != '0) && (i_length <= DEPTH_L);
  assign w_start_go   = (r_state == SEQ_IDLE) && i_start && w_len_ok;
  assign w_last       = ({1'b0, r_step} == (r_len - 1'b1));
  assign w_wait_end   = (r_wait_cnt == LAT_M1);
  assign w_capture_op = op_has_result(r_sel);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      SEQ_IDLE: begin
        if (w_start_go) begin
          w_state_nxt = SEQ_ISSUE;
        end
      end
      SEQ_ISSUE: begin
        w_state_nxt = SEQ_WAIT;
      end
      SEQ_WAIT: begin
        if (w_wait_end) begin
          if (w_capture_op) begin
            w_state_nxt = SEQ_CAPTURE;
          end else if (w_last) begin
            w_state_nxt = SEQ_DONE;
          end else begin
            w_state_nxt = SEQ_ISSUE;
          end
        end
      end
      SEQ_CAPTURE: begin
        w_state_nxt = w_last ? SEQ_DONE : SEQ_ISSUE;
      end
      SEQ_DONE: begin
        w_state_nxt = SEQ_IDLE;
      end
      default: begin
        w_state_nxt = SEQ_IDLE;
      end
    endcase
    // Abort overrides every other transition out of a non-IDLE state,
    // which also keeps DONE and CAPTURE from ever being entered.
    if (i_abort && (r_state != SEQ_IDLE)) begin
      w_state_nxt = SEQ_IDLE;
    end
  end

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= SEQ_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // WAIT counter: zero everywhere except while counting inside WAIT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state == SEQ_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 3'd1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Step advances on the edge entering each ISSUE after the first, so it
  // names the step on the bus during ISSUE and keeps it afterwards.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_step <= '0;
      r_len  <= '0;
    end else if (w_start_go) begin
      r_step <= '0;
      r_len  <= i_length;
    end else if (w_state_nxt == SEQ_ISSUE) begin
      r_step <= r_step + 1'b1;
    end
  end

  // Selector/data are loaded only when an issue is about to happen and are
  // otherwise held, so the ALU bus stays stable between issues.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel  <= '0;
      r_data <= '0;
    end else if (w_state_nxt == SEQ_ISSUE) begin
      r_sel  <= w_fetch[11:8];
      r_data <= w_fetch[7:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result <= '0;
    end else if (w_state_nxt == SEQ_CAPTURE) begin
      r_result <= i_alu_y;
    end
  end

  // Misuse while busy always flags. From IDLE a start re-arms the flag
  // according to its length: a good run clears it, a bad length sets it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prog_err <= 1'b0;
    end else if (w_busy && (i_start || i_prog_we)) begin
      r_prog_err <= 1'b1;
    end else if ((r_state == SEQ_IDLE) && i_start) begin
      r_prog_err <= !w_len_ok;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: single-bit strobes decode straight from the state register so
  // they fall to 0 the instant reset asserts.
  // ---------------------------------------------------------------------
  assign o_sel_out      = r_sel;
  assign o_data_out     = r_data;
  assign o_alu_enable   = (r_state == SEQ_ISSUE);
  assign o_result       = r_result;
  assign o_result_valid = (r_state == SEQ_CAPTURE);
  assign o_step         = r_step;
  assign o_busy         = w_busy;
  assign o_done         = (r_state == SEQ_DONE);
  assign o_prog_err     = r_prog_err;
  assign o_state        = r_state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
// Bench for alu_op_sequencer paired with a small accumulator-style ALU model
// (Y and B registers, Y valid one cycle after the enable edge, B=0 and Y=0
// after reset).
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int DEPTH   = 8;
  localparam int AW      = 3;
  localparam int ALU_LAT = 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          prog_we   = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [11:0]   prog_data = '0;
  logic [AW:0]   length    = '0;
  logic          start     = 1'b0;
  logic          abort     = 1'b0;
  logic [3:0]    sel_out;
  logic [7:0]    data_out;
  logic          alu_enable;
  logic [7:0]    alu_y;
  logic [7:0]    result;
  logic          result_valid;
  logic [AW-1:0] step;
  logic          busy;
  logic          done;
  logic          prog_err;
  logic [2:0]    dbg_state;

  alu_op_sequencer #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .ALU_LAT (ALU_LAT)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_prog_we      (prog_we),
    .i_prog_addr    (prog_addr),
    .i_prog_data    (prog_data),
    .i_length       (length),
    .i_start        (start),
    .i_abort        (abort),
    .o_sel_out      (sel_out),
    .o_data_out     (data_out),
    .o_alu_enable   (alu_enable),
    .i_alu_y        (alu_y),
    .o_result       (result),
    .o_result_valid (result_valid),
    .o_step         (step),
    .o_busy         (busy),
    .o_done         (done),
    .o_prog_err     (prog_err),
    .o_state        (dbg_state)
  );

  // ---------------- ALU semantics ----------------
  // Returns {Y_next, B_next}.
  function automatic logic [15:0] alu_op(input logic [3:0] op, input logic [7:0] d,
                                         input logic [7:0] y, input logic [7:0] b);
    logic [7:0] ny;
    logic [7:0] nb;
    ny = y;
    nb = b;
    case (op)
      4'h0: ny = b + d;
      4'h1: ny = b - d;
      4'h2: ny = y & d;
      4'h3: ny = y | d;
      4'h4: ny = y ^ d;
      4'h5: ny = {y[6:0], 1'b0};
      4'h6: ny = {1'b0, y[7:1]};
      4'h7: ny = {y[6:0], y[7]};
      4'h8: ny = {y[0], y[7:1]};
      4'h9: ny = y + 8'd1;
      4'hA: ny = y - 8'd1;
      4'hB: ny = ~y;
      4'hC: ny = 8'd0 - y;
      4'hD: nb = y;
      4'hE: begin ny = b; nb = y; end
      default: nb = d;
    endcase
    return {ny, nb};
  endfunction

  // ALU model driven by the sequencer
  logic [7:0] alu_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_y <= '0;
      alu_b <= '0;
    end else if (alu_enable) begin
      {alu_y, alu_b} <= alu_op(sel_out, data_out, alu_y, alu_b);
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [AW+11:0] exp_iss_q[$];   // {step, opcode, operand}
  logic [7:0]     exp_q[$];       // expected captured results

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  // reference model state
  logic [11:0] prog_img [DEPTH];
  logic [7:0]  m_y = '0;
  logic [7:0]  m_b = '0;
  int          run_id = 0;

  task automatic predict(input int len);
    for (int i = 0; i < len; i++) begin
      exp_iss_q.push_back({AW'(i), prog_img[i]});
      {m_y, m_b} = alu_op(prog_img[i][11:8], prog_img[i][7:0], m_y, m_b);
      if (prog_img[i][11:8] <= 4'hC) exp_q.push_back(m_y);
    end
  endtask

  // ---------------- monitor ----------------
  int         cyc = 0;
  int         en_cnt = 0;
  int         done_cnt = 0;
  int         last_en_cyc = 0;
  int         last_en_run = -1;
  logic [3:0] last_op = '0;
  logic       prev_en = 1'b0;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic [AW+11:0] e;
    logic [7:0]     r;
    if (!rst_n) begin
      prev_en = 1'b0;
    end else begin
      if (alu_enable) begin
        en_cnt++;
        chk("issue_expected", 32'(exp_iss_q.size() > 0), 32'd1);
        chk("enable_not_back_to_back", 32'(prev_en), 32'd0);
        if (last_en_run == run_id)
          chk("issue_gap", 32'(cyc - last_en_cyc),
              32'((last_op <= 4'hC) ? ALU_LAT + 2 : ALU_LAT + 1));
        if (exp_iss_q.size() > 0) begin
          e = exp_iss_q.pop_front();
          chk("issue_step_sel_data", 32'({step, sel_out, data_out}), 32'(e));
          last_op = e[11:8];
        end else begin
          last_op = sel_out;
        end
        last_en_cyc = cyc;
        last_en_run = run_id;
      end
      prev_en = alu_enable;
      if (result_valid) begin
        chk("result_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          r = exp_q.pop_front();
          chk("result_value", 32'(result), 32'(r));
        end
      end
      if (done) begin
        done_cnt++;
        chk("busy_low_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    exp_iss_q.delete();
    exp_q.delete();
    m_y = '0;
    m_b = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic write_prog(input logic [AW-1:0] a, input logic [11:0] d);
    @(posedge clk);
    #1 prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clk);
    #1 prog_we = 1'b0;
  endtask

  task automatic load_prog(input int n);
    for (int i = 0; i < n; i++) write_prog(AW'(i), prog_img[i]);
  endtask

  task automatic start_run(input int len);
    @(posedge clk);
    #1 length = (AW+1)'(len); start = 1'b1; run_id++;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int k = 0; k < 300 && done_cnt == d0; k++) @(negedge clk);
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("issue_queue_drained", 32'(exp_iss_q.size()), 32'd0);
    chk("result_queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_issue(input int s);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (alu_enable && (step == AW'(s))) found = 1'b1;
    end
    chk("issue_seen", 32'(found), 32'd1);
  endtask

  // Expectations of the demo program {LOAD 05, ADD, SHL, NOT} from Y=B=0
  task automatic push_demo();
    exp_iss_q.push_back({3'd0, 12'hF05});
    exp_iss_q.push_back({3'd1, 12'h000});
    exp_iss_q.push_back({3'd2, 12'h500});
    exp_iss_q.push_back({3'd3, 12'hB00});
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'hF5);
  endtask

  task automatic set_demo();
    prog_img[0] = 12'hF05;
    prog_img[1] = 12'h000;
    prog_img[2] = 12'h500;
    prog_img[3] = 12'hB00;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_sel"},          32'(sel_out),      32'd0);
    chk({tag, "_data"},         32'(data_out),     32'd0);
    chk({tag, "_enable"},       32'(alu_enable),   32'd0);
    chk({tag, "_result"},       32'(result),       32'd0);
    chk({tag, "_result_valid"}, 32'(result_valid), 32'd0);
    chk({tag, "_step"},         32'(step),         32'd0);
    chk({tag, "_busy"},         32'(busy),         32'd0);
    chk({tag, "_done"},         32'(done),         32'd0);
    chk({tag, "_prog_err"},     32'(prog_err),     32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    int e0;
    int len;

    // reset state
    #1 rst_n = 1'b0;
    #3 check_all_zero("reset");
    do_reset();

    // demo program: results, spacing, done
    set_demo();
    load_prog(4);
    push_demo();
    d0 = done_cnt; e0 = en_cnt;
    start_run(4);
    wait_done(d0);
    chk("demo_final_result", 32'(result), 32'hF5);
    chk("demo_final_step", 32'(step), 32'd3);
    chk("demo_enable_count", 32'(en_cnt - e0), 32'd4);

    // abort in WAIT of step 2
    do_reset();
    load_prog(4);
    exp_iss_q.push_back({3'd0, 12'hF05});
    exp_iss_q.push_back({3'd1, 12'h000});
    exp_iss_q.push_back({3'd2, 12'h500});
    exp_q.push_back(8'h05);
    d0 = done_cnt;
    start_run(4);
    wait_issue(2);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy_low", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_result_kept", 32'(result), 32'h05);
    chk("abort_no_more_issues", 32'(exp_iss_q.size()), 32'd0);
    chk("abort_no_capture", 32'(exp_q.size()), 32'd0);

    // start and prog_we while busy
    do_reset();
    load_prog(4);
    push_demo();
    d0 = done_cnt;
    start_run(4);
    wait_issue(0);
    @(posedge clk);
    #1 start = 1'b1; prog_we = 1'b1; prog_addr = 3'd1; prog_data = 12'h900;
    @(posedge clk);
    #1 start = 1'b0; prog_we = 1'b0;
    wait_done(d0);
    chk("busy_misuse_prog_err", 32'(prog_err), 32'd1);
    chk("busy_misuse_result", 32'(result), 32'hF5);
    // rerun from Y=F5,B=05: same sequence if entry 1 is still ADD 00
    push_demo();
    d0 = done_cnt;
    start_run(4);
    wait_done(d0);
    chk("rerun_prog_err_cleared", 32'(prog_err), 32'd0);

    // bad lengths
    do_reset();
    load_prog(4);
    e0 = en_cnt;
    start_run(0);
    repeat (6) @(negedge clk);
    chk("len0_prog_err", 32'(prog_err), 32'd1);
    chk("len0_no_enable", 32'(en_cnt - e0), 32'd0);
    chk("len0_not_busy", 32'(busy), 32'd0);
    predict(1);
    d0 = done_cnt;
    start_run(1);
    wait_done(d0);
    chk("len1_prog_err_cleared", 32'(prog_err), 32'd0);
    e0 = en_cnt;
    start_run(DEPTH + 1);
    repeat (6) @(negedge clk);
    chk("len_over_prog_err", 32'(prog_err), 32'd1);
    chk("len_over_no_enable", 32'(en_cnt - e0), 32'd0);

    // full-depth random program
    for (int i = 0; i < DEPTH; i++) prog_img[i] = 12'($urandom_range(0, 4095));
    load_prog(DEPTH);
    predict(DEPTH);
    d0 = done_cnt; e0 = en_cnt;
    start_run(DEPTH);
    wait_done(d0);
    chk("full_enable_count", 32'(en_cnt - e0), 32'(DEPTH));
    chk("full_final_step", 32'(step), 32'(DEPTH - 1));

    // random lengths and programs
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, DEPTH);
      for (int i = 0; i < len; i++) prog_img[i] = 12'($urandom_range(0, 4095));
      load_prog(len);
      predict(len);
      d0 = done_cnt; e0 = en_cnt;
      start_run(len);
      wait_done(d0);
      chk("rand_enable_count", 32'(en_cnt - e0), 32'(len));
      chk("rand_final_step", 32'(step), 32'(len - 1));
    end

    // asynchronous reset in WAIT, then a fresh run
    do_reset();
    set_demo();
    load_prog(4);
    push_demo();
    start_run(4);
    wait_issue(1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrun_reset");
    do_reset();
    load_prog(4);
    push_demo();
    d0 = done_cnt;
    start_run(4);
    wait_done(d0);
    chk("after_reset_result", 32'(result), 32'hF5);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
